// File: rtl/fft_peak_streamer.sv
// rtl/fft_peak_streamer.sv - reads one FFT magnitude frame from BRAM and streams it to the peak finder
//
// Ports:
//   clk, reset          : sole clock, synchronous active-high reset
//   go                  : start-frame request, sampled only while idle
//   bram_addr/bram_dout : magnitude RAM read port (data valid one cycle after address)
//   stream_start        : one-cycle pulse with bin 0
//   stream_enable       : high on every cycle a bin is presented
//   stream_data         : bin magnitude, bins below MIN_BIN forced to 0
//   peak_index_in       : peak finder result
//   peak_bin            : peak index of the last completed frame
//   busy, done          : frame in progress / one-cycle completion pulse

module fft_peak_streamer #(
  parameter int DATA_WIDTH  = 18,
  parameter int INDEX_WIDTH = 12,
  parameter int MIN_BIN     = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   go,
  output logic [INDEX_WIDTH-1:0] bram_addr,
  input  logic [DATA_WIDTH-1:0]  bram_dout,
  output logic                   stream_start,
  output logic                   stream_enable,
  output logic [DATA_WIDTH-1:0]  stream_data,
  input  logic [INDEX_WIDTH-1:0] peak_index_in,
  output logic [INDEX_WIDTH-1:0] peak_bin,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_STREAM,
    S_SETTLE
  } state_t;

  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = '1;

  state_t                 state;
  state_t                 state_next;
  logic [INDEX_WIDTH-1:0] idx;
  logic                   masked;

  // Low-bin mask; comparing in int keeps MIN_BIN >= 2^INDEX_WIDTH meaningful
  // (every bin masked) instead of truncating the threshold.
  assign masked      = (int'(idx) < MIN_BIN);
  assign stream_data = (stream_enable && !masked) ? bram_dout : '0;

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:   if (go) state_next = S_PRIME;
      S_PRIME:  state_next = S_STREAM;
      S_STREAM: if (idx == LAST_IDX) state_next = S_SETTLE;
      S_SETTLE: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      idx           <= '0;
      bram_addr     <= '0;
      stream_start  <= 1'b0;
      stream_enable <= 1'b0;
      peak_bin      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state <= state_next;
      done  <= (state == S_SETTLE);
      unique case (state)
        S_IDLE: begin
          bram_addr <= '0;
          if (go) busy <= 1'b1;
        end
        S_PRIME: begin
          // Address 0 was issued during PRIME, so bin 0 data lands with idx 0.
          idx           <= '0;
          bram_addr     <= INDEX_WIDTH'(1);
          stream_start  <= 1'b1;
          stream_enable <= 1'b1;
        end
        S_STREAM: begin
          stream_start <= 1'b0;
          // Address runs one bin ahead of idx; the wrap on the last bin reads
          // data nobody consumes.
          bram_addr    <= idx + INDEX_WIDTH'(2);
          if (idx == LAST_IDX) begin
            stream_enable <= 1'b0;
          end else begin
            idx <= idx + INDEX_WIDTH'(1);
          end
        end
        S_SETTLE: begin
          peak_bin <= peak_index_in;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fft_peak_streamer.md
# fft_peak_streamer

Frame streamer feeding the serial peak-finder stage of the tuning pipeline. On a `go` pulse (FFT frame complete) it reads every bin magnitude out of the FFT magnitude BRAM and presents one datum per cycle with the `start`/`enable` framing the peak finder consumes. When the frame is finished it latches the peak finder's result as `peak_bin` and pulses `done`. It is the read side of the magnitude RAM and the transmit side of the peak-finder stream.

## Interface
- `DATA_WIDTH`, 18: magnitude width, BRAM data and stream data.
- `INDEX_WIDTH`, 12: bin address/index width; frame length is 2^INDEX_WIDTH bins (4096).
- `MIN_BIN`, 2: bins with index < MIN_BIN are streamed as 0 (DC/low-bin mask).
- `clk` input 1: sole clock; all logic on posedge.
- `reset` input 1: synchronous, active-high.
- `go` input 1: start-frame request; sampled only in IDLE.
- `bram_addr` output INDEX_WIDTH: magnitude RAM read address.
- `bram_dout` input DATA_WIDTH: RAM read data, valid one cycle after `bram_addr`.
- `stream_start` output 1: one-cycle pulse aligned with bin 0.
- `stream_enable` output 1: high on every cycle a datum is presented, including the start cycle.
- `stream_data` output DATA_WIDTH: current bin magnitude.
- `peak_index_in` input INDEX_WIDTH: peak finder result.
- `peak_bin` output INDEX_WIDTH: peak index of the last completed frame.
- `busy` output 1: high from the cycle after `go` until `done`.
- `done` output 1: one-cycle pulse when `peak_bin` updates.

## Operation
- States: IDLE → PRIME → STREAM → SETTLE → IDLE.
- IDLE: `busy` = 0. `go` = 1 moves to PRIME with `bram_addr` = 0 and `busy` = 1.
- PRIME: exactly one cycle. Moves to STREAM with `bram_addr` = 1, `idx` = 0, `stream_start` = 1, `stream_enable` = 1.
- STREAM: `idx` counts 0..2^INDEX_WIDTH−1, one per cycle. `bram_addr` = `idx` + 1, mod 2^INDEX_WIDTH; the wrap on the final cycle is harmless and its read data is ignored.
  - `stream_data` = (`idx` < MIN_BIN) ? 0 : `bram_dout`. This is a combinational mux from registered `idx`.
  - `stream_start` is high only when `idx` = 0.
  - After `idx` = 2^INDEX_WIDTH−1, go to SETTLE and drop `stream_enable`.
- SETTLE: one cycle, waiting for the downstream result to settle. On exit: `peak_bin` ← `peak_index_in`, `done` = 1 for one cycle, `busy` = 0, return to IDLE.
- Framing rule: the downstream index counter is free-running and advances on every `stream_enable` cycle. Each frame is therefore exactly 2^INDEX_WIDTH enable cycles. A frame is never shortened, stalled or paused.
- `go` during PRIME, STREAM or SETTLE is ignored; no queuing.
- `go` in the same cycle `done` is high is accepted, since the FSM is in IDLE.
- MIN_BIN = 0 disables masking. MIN_BIN ≥ 2^INDEX_WIDTH streams all zeros.

## Timing
- Reset values: state IDLE; `bram_addr` = 0, `stream_start` = 0, `stream_enable` = 0, `stream_data` = 0, `peak_bin` = 0, `busy` = 0, `done` = 0.
- `go` sampled at cycle T:
  - `busy` rises at T+1.
  - `stream_start`/`stream_enable` rise at T+2, carrying bin 0.
  - Last datum (bin 4095) at T+4097.
  - `stream_enable` falls at T+4098 (SETTLE).
  - `done` and the `peak_bin` update at T+4099; `busy` falls at T+4099.
- Throughput: one frame per 4099 cycles back-to-back.
- Reset mid-frame: immediate return to IDLE; the partial frame is abandoned and no `done` is issued. `reset` must also clear the downstream index counter, so both are shared on the system reset.
- `reset` and `go` in the same cycle: reset wins.

## Test plan
- RAM[i] = i, MIN_BIN = 2; pulse `go` at T. Expect:
  - `start` only at T+2;
  - `stream_data` = 0, 0, 2, 3, …, 4095 on T+2..T+4097;
  - exactly 4096 enable cycles;
  - `done` at T+4099.
- RAM all 5 except RAM[1000] = 0x3FFFF; peak finder model returns the true index. Expect `peak_bin` = 1000 with `done`, and `peak_bin` held until the next frame.
- RAM[0] = RAM[1] = 0x3FFFF, rest 7, MIN_BIN = 2. Expect bins 0–1 streamed as 0; `peak_bin` ≠ 0, 1.
- Pulse `go` at T+10 and T+3000 (mid-frame), then again at T+4099. Expect the mid-frame pulses ignored, with the second frame starting `start` at T+4101.
- Assert `reset` at T+2000. Expect all outputs 0 next cycle, no `done`, and a following `go` producing a full, correct 4096-cycle frame.
